sincos_sched: RTL and testbench
===============================

// Module: sincos_sched
// PURPOSE
// - Time-multiplexes one shared pipelined sin core to produce sin and cos of NUM_JOINTS joint angles per request.
// - Sits in the t_block, between the joint-angle registers and the transform-matrix builders.
// - Replaces per-joint sin/cos instances. cos is issued as sin(angle + PI/2), range-reduced before issue.
// - Angles and results are 48-bit two's complement fixed point, 24 fractional bits.
// PARAMETERS
// - NUM_JOINTS  6   joints per run; ops per run = 2*NUM_JOINTS
// - SIN_LAT     12  cycles from core_angle registered to matching core_sin valid (>=1)
// PORTS
// - clk        in   1                  clock
// - rst        in   1                  reset, asynchronous, active-high
// - start      in   1                  run request; sampled only in IDLE
// - angles     in   48*NUM_JOINTS      joint j at [48j+47:48j]; latched on accepted start
// - busy       out  1                  high from the cycle after accepted start until done
// - done       out  1                  one-cycle pulse; all results valid
// - sin_out    out  48*NUM_JOINTS      sin of joint j, same packing as angles
// - cos_out    out  48*NUM_JOINTS      cos of joint j, same packing
// - core_en    out  1                  enable to the shared sin core
// - core_angle out  48                 registered operand to the sin core
// - core_sin   in   48                 sin core result, SIN_LAT cycles after operand
// BEHAVIOUR
// - Reset: busy=0, done=0, core_en=0, core_angle=0, sin_out=0, cos_out=0, issue counter=0, tag pipe all invalid, FSM=IDLE.
// - FSM states: IDLE -> ISSUE on start; ISSUE -> DRAIN after op 2N-1 issued; DRAIN -> DONE when tag pipe empty; DONE -> IDLE.
// - start is ignored outside IDLE; no queuing. start in DONE cycle is ignored.
// - Issue order: op k = 2j is sin(j), op k = 2j+1 is cos(j); one op per cycle, no bubbles.
// - sin op operand = angle_j.
// - cos op operand: a = angle_j + 48'd26353589; if (a > 48'd52707178 && a[47]==0) then a - 48'd105414357, else a. All modulo 2^48.
// - core_en = 1 in ISSUE and DRAIN, 0 otherwise.
// - Tag pipe: SIN_LAT-deep shift register of {valid, k}, advanced every cycle.
// - Tag with valid=1 leaving the pipe writes core_sin into sin_out[j] (even k) or cos_out[j] (odd k).
// - Timing, start sampled at edge T:
//   - op k on core_angle during cycle T+1+k;
//   - result written at edge T+1+k+SIN_LAT;
//   - done=1 during cycle T+2N+SIN_LAT+1, i.e. the DONE state.
// - busy=1 during ISSUE and DRAIN; busy=0 in DONE and IDLE.
// - Outputs hold the last written values until overwritten by a later run or reset.
// - Partial updates are visible mid-run; consumers sample on done.
// - rst mid-run clears the tag pipe, so core_sin values still in flight inside the core are discarded.
// - After rst the block is in IDLE and a new start is accepted immediately.
// CONFIGURATION
// - SINCOS_REUSE_EN defined:
//   - per-joint last_angle registers (reset 0, valid bits reset 0) are written at done with that run's latched angles;
//   - on a run, joints with valid last_angle equal to the new angle issue no ops; their sin/cos outputs are retained;
//   - the issue counter skips to the next changed joint;
//   - done fires SIN_LAT+2 cycles after the last issued op;
//   - if no joint changed, done fires at T+2 and there is no ISSUE/DRAIN (busy=1 only in cycle T+1).
// - SINCOS_REUSE_EN undefined: every run issues all 2N ops; no last_angle storage.
// TESTING
// - Bench uses a behavioural core model: delay SIN_LAT, core_sin = core_angle (identity), to check routing.
// - Reset then start, angles all 0 -> done at T+2*6+12+1 = T+25; sin_out[j]=0, cos_out[j]=48'd26353589.
// - angle0=48'd52707178 (PI) -> sin_out[0]=48'd52707178; cos_out[0]=48'hFFFFFE6DE04A (-26353590).
// - angle1 = -PI/2 = 48'hFFFFFE6DE04B -> cos_out[1]=0; core_angle sequence is checked op by op against the issue order.
// - start pulsed again during ISSUE and in the DONE cycle -> ignored; exactly one done pulse and no core_angle change.
// - rst asserted at T+8, released at T+10, start at T+12 with new angles -> outputs reflect only the second run.
//   Stale in-flight results are never written.
// - SINCOS_REUSE_EN: run twice with identical angles -> second done at T+2, no core_angle activity.
//   Then change joint 3 only -> exactly 2 ops issued, other outputs unchanged.

Source files
------------

// File: rtl/sincos_sched.sv
// Shares one pipelined sin core across NUM_JOINTS angles, issuing sin(a) then sin(a+PI/2) per joint.
// Optional `define SINCOS_REUSE_EN skips joints whose angle is unchanged since the last completed run.
module sincos_sched #(
  parameter int NUM_JOINTS = 6,
  parameter int SIN_LAT    = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [48*NUM_JOINTS-1:0]  angles,
  output logic                      busy,
  output logic                      done,
  output logic [48*NUM_JOINTS-1:0]  sin_out,
  output logic [48*NUM_JOINTS-1:0]  cos_out,
  output logic                      core_en,
  output logic [47:0]               core_angle,
  input  logic [47:0]               core_sin
);

  localparam int JW = (NUM_JOINTS > 1) ? $clog2(NUM_JOINTS) : 1;
  localparam int KW = $clog2(2 * NUM_JOINTS);
  localparam logic [47:0] HALF_PI = 48'd26353589;
  localparam logic [47:0] PI      = 48'd52707178;
  localparam logic [47:0] TWO_PI  = 48'd105414357;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, SKIP, DONE} state_t;

  state_t          state_reg;
  logic [JW-1:0]   j_reg;
  logic            phase_reg;
  logic            cur_valid_reg;
  logic [KW-1:0]   cur_k_reg;
  logic [NUM_JOINTS-1:0] mask_reg;
  logic [47:0]     angle_reg [NUM_JOINTS];
  logic [47:0]     angle_in  [NUM_JOINTS];
  logic [47:0]     sin_reg   [NUM_JOINTS];
  logic [47:0]     cos_reg   [NUM_JOINTS];
  logic            tag_valid_reg [SIN_LAT];
  logic [KW-1:0]   tag_k_reg     [SIN_LAT];

  logic [NUM_JOINTS-1:0] new_mask;
  logic [JW-1:0]   first_j;
  logic            any_changed;
  logic [JW-1:0]   next_j;
  logic            has_next;
  logic            pipe_quiet;

  // cos(a) = sin(a + PI/2), folded back into (-PI, PI] before it reaches the core.
  function automatic logic [47:0] op_operand(input logic [47:0] ang, input logic is_cos);
    logic [47:0] a;
    a = ang + HALF_PI;
    if (!is_cos)
      return ang;
    if (a > PI && !a[47])
      return a - TWO_PI;
    return a;
  endfunction

  function automatic logic [KW-1:0] make_k(input logic [JW-1:0] j, input logic ph);
    return KW'({j, ph});
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_JOINTS; gi++) begin : g_joint
      assign angle_in[gi]          = angles[48*gi +: 48];
      assign sin_out[48*gi +: 48]  = sin_reg[gi];
      assign cos_out[48*gi +: 48]  = cos_reg[gi];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sin_reg[gi] <= '0;
          cos_reg[gi] <= '0;
        end else if (tag_valid_reg[SIN_LAT-1]) begin
          if (tag_k_reg[SIN_LAT-1] == KW'(2*gi))
            sin_reg[gi] <= core_sin;
          if (tag_k_reg[SIN_LAT-1] == KW'(2*gi+1))
            cos_reg[gi] <= core_sin;
        end
      end
    end

    // Tag pipe runs in lockstep with the core; slot SIN_LAT-1 lines up with core_sin.
    for (gi = 0; gi < SIN_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            tag_valid_reg[gi] <= 1'b0;
            tag_k_reg[gi]     <= '0;
          end else begin
            tag_valid_reg[gi] <= cur_valid_reg;
            tag_k_reg[gi]     <= cur_k_reg;
          end
        end
      end else begin : g_body
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            tag_valid_reg[gi] <= 1'b0;
            tag_k_reg[gi]     <= '0;
          end else begin
            tag_valid_reg[gi] <= tag_valid_reg[gi-1];
            tag_k_reg[gi]     <= tag_k_reg[gi-1];
          end
        end
      end
    end
  endgenerate

`ifdef SINCOS_REUSE_EN
  logic [47:0] last_angle_reg [NUM_JOINTS];
  logic        last_valid_reg [NUM_JOINTS];

  generate
    for (gi = 0; gi < NUM_JOINTS; gi++) begin : g_reuse
      assign new_mask[gi] = !last_valid_reg[gi] || (last_angle_reg[gi] != angle_in[gi]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          last_angle_reg[gi] <= '0;
          last_valid_reg[gi] <= 1'b0;
        end else if (state_reg == DONE) begin
          last_angle_reg[gi] <= angle_reg[gi];
          last_valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate
`else
  assign new_mask = '1;
`endif

  always_comb begin
    first_j     = '0;
    any_changed = 1'b0;
    next_j      = '0;
    has_next    = 1'b0;
    for (int i = NUM_JOINTS-1; i >= 0; i--) begin
      if (new_mask[i]) begin
        first_j     = JW'(i);
        any_changed = 1'b1;
      end
      if (mask_reg[i] && (i > int'(j_reg))) begin
        next_j   = JW'(i);
        has_next = 1'b1;
      end
    end
  end

  // Quiet means nothing will remain in flight after this edge.
  always_comb begin
    pipe_quiet = !cur_valid_reg;
    for (int i = 0; i < SIN_LAT-1; i++)
      if (tag_valid_reg[i])
        pipe_quiet = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      core_en       <= 1'b0;
      core_angle    <= '0;
      j_reg         <= '0;
      phase_reg     <= 1'b0;
      cur_valid_reg <= 1'b0;
      cur_k_reg     <= '0;
      mask_reg      <= '0;
      for (int i = 0; i < NUM_JOINTS; i++)
        angle_reg[i] <= '0;
    end else begin
      done          <= 1'b0;
      cur_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_JOINTS; i++)
              angle_reg[i] <= angle_in[i];
            mask_reg <= new_mask;
            busy     <= 1'b1;
            if (any_changed) begin
              core_angle    <= op_operand(angle_in[first_j], 1'b0);
              cur_valid_reg <= 1'b1;
              cur_k_reg     <= make_k(first_j, 1'b0);
              j_reg         <= first_j;
              phase_reg     <= 1'b1;
              core_en       <= 1'b1;
              state_reg     <= ISSUE;
            end else begin
              state_reg <= SKIP;
            end
          end
        end
        ISSUE: begin
          core_angle    <= op_operand(angle_reg[j_reg], phase_reg);
          cur_valid_reg <= 1'b1;
          cur_k_reg     <= make_k(j_reg, phase_reg);
          if (!phase_reg) begin
            phase_reg <= 1'b1;
          end else if (has_next) begin
            j_reg     <= next_j;
            phase_reg <= 1'b0;
          end else begin
            j_reg     <= '0;
            phase_reg <= 1'b0;
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (pipe_quiet) begin
            busy      <= 1'b0;
            core_en   <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        SKIP: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_sched.sv
// Bench for sincos_sched with an identity sin core; follows SINCOS_REUSE_EN when defined.
module tb_sincos_sched;
  localparam int NJ  = 6;
  localparam int LAT = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [48*NJ-1:0]  angles = '0;
  logic              busy, done, core_en;
  logic [48*NJ-1:0]  sin_out, cos_out;
  logic [47:0]       core_angle, core_sin;

  sincos_sched #(.NUM_JOINTS(NJ), .SIN_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .angles(angles),
    .busy(busy), .done(done), .sin_out(sin_out), .cos_out(cos_out),
    .core_en(core_en), .core_angle(core_angle), .core_sin(core_sin)
  );

  always #5 clk = ~clk;

  // Identity core: SIN_LAT registers, deliberately not reset so stale values keep flowing.
  logic [47:0] core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= core_angle;
    for (int i = 1; i < LAT; i++)
      core_pipe[i] <= core_pipe[i-1];
  end
  assign core_sin = core_pipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0, done_cnt = 0, en_cnt = 0, run_id = 0;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (core_en) en_cnt++;
  end

  logic [47:0] op_q [$];
  logic [47:0] res_q [$];
  logic [47:0] m_sin [NJ], m_cos [NJ], m_last [NJ];
  bit          m_valid [NJ];
  logic [47:0] m_core = '0;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [47:0] cos_operand(input logic [47:0] a);
    logic [47:0] s;
    s = a + 48'd26353589;
    if (!s[47] && s > 48'd52707178)
      s = s - 48'd105414357;
    return s;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < NJ; j++) begin
      m_sin[j] = '0; m_cos[j] = '0; m_last[j] = '0; m_valid[j] = 1'b0;
    end
    m_core = '0;
  endtask

  task automatic run_job(input logic [48*NJ-1:0] ang, input bit extra_starts, input bit check_clean);
    int nops, t0, d0, e0, lat, exp_lat, guard;
    logic [47:0] a, e;
    bit changed;
    nops = 0;
    for (int j = 0; j < NJ; j++) begin
      a = ang[48*j +: 48];
`ifdef SINCOS_REUSE_EN
      changed = !m_valid[j] || (m_last[j] != a);
`else
      changed = 1'b1;
`endif
      if (changed) begin
        op_q.push_back(a);
        op_q.push_back(cos_operand(a));
        m_sin[j] = a;
        m_cos[j] = cos_operand(a);
        nops += 2;
      end
      m_last[j]  = a;
      m_valid[j] = 1'b1;
    end
    for (int j = 0; j < NJ; j++) begin
      res_q.push_back(m_sin[j]);
      res_q.push_back(m_cos[j]);
    end
    exp_lat = (nops > 0) ? nops + LAT : 1;
    d0 = done_cnt;
    e0 = en_cnt;

    @(negedge clk);
    angles = ang;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    for (int i = 0; i < nops; i++) begin
      if (i > 0) @(negedge clk);
      e = op_q.pop_front();
      check("core_angle", core_angle, e);
      check("busy_issue", 48'(busy), 48'd1);
      m_core = e;
      if (extra_starts && i == 2) start = 1'b1;
      if (extra_starts && i == 4) start = 1'b0;
    end
    if (check_clean) begin
      guard = 0;
      while (cyc < t0 + LAT && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      check("no_stale", 48'(|{sin_out, cos_out}), 48'd0);
    end
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    lat = cyc - t0;
    check("done_latency", 48'(lat), 48'(exp_lat));
    check("busy_in_done", 48'(busy), 48'd0);
    for (int j = 0; j < NJ; j++) begin
      check("sin_out", sin_out[48*j +: 48], res_q.pop_front());
      check("cos_out", cos_out[48*j +: 48], res_q.pop_front());
    end
    if (extra_starts) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after", 48'(busy), 48'd0);
    repeat (3) @(negedge clk);
    check("done_pulses", 48'(done_cnt - d0), 48'd1);
    check("en_cycles", 48'(en_cnt - e0), 48'((nops > 0) ? nops + LAT : 0));
    check("core_angle_hold", core_angle, m_core);
    $display("run %0d: ops=%0d done_latency=%0d extra_starts=%0d", run_id, nops, lat, extra_starts);
    run_id++;
  endtask

  logic [48*NJ-1:0] ang_a, ang_b, ang_c;
  int t_rst;

  initial begin
    model_reset();
    ang_a = '0;
    ang_b = {48'd26353589, 48'h000001000000, 48'hFFFFFCDBC096,
             48'd52707177, 48'hFFFFFE6DE04B, 48'd52707178};
    ang_c = {48'h000000ABCDEF, 48'hFFFFFF000000, 48'd12345,
             48'd1, 48'd40000000, 48'hFFFFFFF00000};

    repeat (3) @(negedge clk);
    check("rst_busy", 48'(busy), 48'd0);
    check("rst_done", 48'(done), 48'd0);
    check("rst_core_en", 48'(core_en), 48'd0);
    check("rst_core_angle", core_angle, 48'd0);
    check("rst_outputs", 48'(|{sin_out, cos_out}), 48'd0);
    rst = 1'b0;

    run_job(ang_a, 1'b0, 1'b0);
    run_job(ang_b, 1'b1, 1'b0);
    check("sin0_pi", sin_out[47:0], 48'd52707178);
    check("cos0_pi", cos_out[47:0], 48'hFFFFFE6DE04A);
    check("cos1_neg_half_pi", cos_out[95:48], 48'd0);
    run_job(ang_b, 1'b0, 1'b0);

    // Abort a run mid-flight, then start again with different angles.
    @(negedge clk);
    angles = ang_a;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_rst = cyc;
    while (cyc < t_rst + 7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_busy", 48'(busy), 48'd0);
    check("midrun_rst_outputs", 48'(|{sin_out, cos_out}), 48'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_job(ang_c, 1'b0, 1'b1);

    ang_c[48*3 +: 48] = 48'h000000777777;
    run_job(ang_c, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
